// File: rtl/cpu6_decq_pkg.sv
// ============================================================================
// Module   : cpu6_decq_pkg
// Summary  : Shared encodings for the cpu6 decode stage and its control bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu6_decq_pkg;

    // The control bundle is 20 fixed bits plus the aluop field.
    // LSB-first layout: muldiv, immtype[2:0], aluop, jal, jump, regwrite, alusrc,
    // branchtype[2:0], mem_unsigned, mem_size[1:0], memwrite, memtoreg,
    // csr_wsc[1:0], csr_rs1uimm, csr.
    localparam int CPU6_ALUOP_W      = 4;
    localparam int CPU6_DCTRL_FIX_W  = 20;
    localparam int CPU6_DCTRL_W      = CPU6_DCTRL_FIX_W + CPU6_ALUOP_W;
    localparam int CPU6_OFF_MULDIV   = 0;
    localparam int CPU6_OFF_IMMTYPE  = 1;
    localparam int CPU6_OFF_ALUOP    = 4;
    localparam int CPU6_OFF_JAL      = CPU6_OFF_ALUOP + CPU6_ALUOP_W;

    localparam logic [3:0] CPU6_ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] CPU6_ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] CPU6_ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] CPU6_ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] CPU6_ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] CPU6_ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] CPU6_ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] CPU6_ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] CPU6_ALU_OP_OR   = 4'd8;
    localparam logic [3:0] CPU6_ALU_OP_AND  = 4'd9;
    localparam logic [3:0] CPU6_ALU_OP_LUI  = 4'd10;

    localparam logic [1:0] CPU6_MEMSIZE_B = 2'd0;
    localparam logic [1:0] CPU6_MEMSIZE_H = 2'd1;
    localparam logic [1:0] CPU6_MEMSIZE_W = 2'd2;

    localparam logic [2:0] CPU6_IMMTYPE_R = 3'd0;
    localparam logic [2:0] CPU6_IMMTYPE_I = 3'd1;
    localparam logic [2:0] CPU6_IMMTYPE_S = 3'd2;
    localparam logic [2:0] CPU6_IMMTYPE_B = 3'd3;
    localparam logic [2:0] CPU6_IMMTYPE_U = 3'd4;
    localparam logic [2:0] CPU6_IMMTYPE_J = 3'd5;

    localparam logic [2:0] CPU6_BRANCHTYPE_NOBRANCH = 3'd0;
    localparam logic [2:0] CPU6_BRANCHTYPE_BEQ      = 3'd1;
    localparam logic [2:0] CPU6_BRANCHTYPE_BNE      = 3'd2;
    localparam logic [2:0] CPU6_BRANCHTYPE_BLT      = 3'd3;
    localparam logic [2:0] CPU6_BRANCHTYPE_BGE      = 3'd4;
    localparam logic [2:0] CPU6_BRANCHTYPE_BLTU     = 3'd5;
    localparam logic [2:0] CPU6_BRANCHTYPE_BGEU     = 3'd6;

    localparam logic [1:0] CPU6_CSR_WSC_NONE = 2'd0;
    localparam logic [1:0] CPU6_CSR_WSC_W    = 2'd1;
    localparam logic [1:0] CPU6_CSR_WSC_S    = 2'd2;
    localparam logic [1:0] CPU6_CSR_WSC_C    = 2'd3;

    localparam logic [6:0] CPU6_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] CPU6_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] CPU6_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] CPU6_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] CPU6_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] CPU6_OPC_OP       = 7'b0110011;
    localparam logic [6:0] CPU6_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] CPU6_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] CPU6_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] CPU6_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] CPU6_OPC_SYSTEM   = 7'b1110011;

    function automatic logic [3:0] cpu6_alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? CPU6_ALU_OP_SUB : CPU6_ALU_OP_ADD;
            3'b001:  return CPU6_ALU_OP_SLL;
            3'b010:  return CPU6_ALU_OP_SLT;
            3'b011:  return CPU6_ALU_OP_SLTU;
            3'b100:  return CPU6_ALU_OP_XOR;
            3'b101:  return alt ? CPU6_ALU_OP_SRA : CPU6_ALU_OP_SRL;
            3'b110:  return CPU6_ALU_OP_OR;
            default: return CPU6_ALU_OP_AND;
        endcase
    endfunction

    // funct3 010/011 are reserved and map to NOBRANCH, which marks them illegal.
    function automatic logic [2:0] cpu6_branch_type(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return CPU6_BRANCHTYPE_BEQ;
            3'b001:  return CPU6_BRANCHTYPE_BNE;
            3'b100:  return CPU6_BRANCHTYPE_BLT;
            3'b101:  return CPU6_BRANCHTYPE_BGE;
            3'b110:  return CPU6_BRANCHTYPE_BLTU;
            3'b111:  return CPU6_BRANCHTYPE_BGEU;
            default: return CPU6_BRANCHTYPE_NOBRANCH;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu6_decq_dec.sv
// ============================================================================
// Module   : cpu6_decq_dec
// Summary  : Combinational RV32I + Zicsr decoder to the cpu6 control bundle.
//            Define CPU6_DEC_RV32M_EN to accept the RV32M mul/div encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu6_decq_dec
    import cpu6_decq_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [31:0]                       instr,
    output logic [CPU6_DCTRL_FIX_W+ALUOP_W-1:0] ctrl,
    output logic                              illinstr
);

    logic [6:0] w_opcode;
    logic [6:0] w_f7;
    logic [2:0] w_f3;
    logic       w_unused;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_unused = ^{instr[24:15], instr[11:7]};

    logic       w_legal, w_csr, w_rs1uimm, w_memtoreg, w_memwrite, w_munsigned;
    logic       w_alusrc, w_regwrite, w_jump, w_jal, w_muldiv;
    logic [1:0] w_wsc, w_msize;
    logic [2:0] w_btype, w_immtype;
    logic [3:0] w_op;

    always_comb begin
        w_legal     = 1'b0;
        w_csr       = 1'b0;
        w_rs1uimm   = 1'b0;
        w_wsc       = CPU6_CSR_WSC_NONE;
        w_memtoreg  = 1'b0;
        w_memwrite  = 1'b0;
        w_msize     = CPU6_MEMSIZE_B;
        w_munsigned = 1'b0;
        w_btype     = CPU6_BRANCHTYPE_NOBRANCH;
        w_alusrc    = 1'b0;
        w_regwrite  = 1'b0;
        w_jump      = 1'b0;
        w_jal       = 1'b0;
        w_op        = CPU6_ALU_OP_ADD;
        w_immtype   = CPU6_IMMTYPE_R;
        w_muldiv    = 1'b0;
        case (w_opcode)
            CPU6_OPC_LOAD: begin
                w_legal     = (w_f3 != 3'b011) && (w_f3[2:1] != 2'b11);
                w_memtoreg  = 1'b1;
                w_regwrite  = 1'b1;
                w_alusrc    = 1'b1;
                w_immtype   = CPU6_IMMTYPE_I;
                w_msize     = w_f3[1:0];
                w_munsigned = w_f3[2];
            end
            CPU6_OPC_STORE: begin
                w_legal    = !w_f3[2] && (w_f3[1:0] != 2'b11);
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_immtype  = CPU6_IMMTYPE_S;
                w_msize    = w_f3[1:0];
            end
            CPU6_OPC_OP_IMM: begin
                if (w_f3 == 3'b001)
                    w_legal = (w_f7 == 7'b0000000);
                else if (w_f3 == 3'b101)
                    w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                else
                    w_legal = 1'b1;
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_immtype  = CPU6_IMMTYPE_I;
                // instr[30] is part of the immediate for addi, so only srai uses it.
                w_op       = cpu6_alu_op(w_f3, (w_f3 == 3'b101) && instr[30]);
            end
            CPU6_OPC_OP: begin
                w_regwrite = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_legal = 1'b1;
                    w_op    = cpu6_alu_op(w_f3, 1'b0);
                end else if (w_f7 == 7'b0100000) begin
                    w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
                    w_op    = cpu6_alu_op(w_f3, 1'b1);
                end
`ifdef CPU6_DEC_RV32M_EN
                else if (w_f7 == 7'b0000001) begin
                    w_legal  = 1'b1;
                    w_muldiv = 1'b1;
                end
`endif
            end
            CPU6_OPC_BRANCH: begin
                w_btype   = cpu6_branch_type(w_f3);
                w_legal   = (w_btype != CPU6_BRANCHTYPE_NOBRANCH);
                w_immtype = CPU6_IMMTYPE_B;
                w_op      = CPU6_ALU_OP_SUB;
            end
            CPU6_OPC_JAL: begin
                w_legal    = 1'b1;
                w_jump     = 1'b1;
                w_jal      = 1'b1;
                w_regwrite = 1'b1;
                w_immtype  = CPU6_IMMTYPE_J;
            end
            CPU6_OPC_JALR: begin
                w_legal    = (w_f3 == 3'b000);
                w_jump     = 1'b1;
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_immtype  = CPU6_IMMTYPE_I;
            end
            CPU6_OPC_LUI: begin
                w_legal    = 1'b1;
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_immtype  = CPU6_IMMTYPE_U;
                w_op       = CPU6_ALU_OP_LUI;
            end
            CPU6_OPC_AUIPC: begin
                w_legal    = 1'b1;
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_immtype  = CPU6_IMMTYPE_U;
            end
            CPU6_OPC_MISC_MEM: begin
                w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001);
            end
            CPU6_OPC_SYSTEM: begin
                // funct3 000 (ecall/ebreak) and 100 are not supported here.
                w_legal    = (w_f3[1:0] != 2'b00);
                w_csr      = 1'b1;
                w_rs1uimm  = w_f3[2];
                w_wsc      = w_f3[1:0];
                w_regwrite = 1'b1;
                w_immtype  = CPU6_IMMTYPE_I;
            end
            default: ;
        endcase
    end

    assign illinstr = !w_legal;
    assign ctrl     = w_legal ? {w_csr, w_rs1uimm, w_wsc, w_memtoreg, w_memwrite, w_msize,
                                 w_munsigned, w_btype, w_alusrc, w_regwrite, w_jump, w_jal,
                                 ALUOP_W'(w_op), w_immtype, w_muldiv}
                              : '0;

endmodule

`default_nettype wire

// File: rtl/cpu6_decq.sv
// ============================================================================
// Module   : cpu6_decq
// Summary  : cpu6 decode stage with a decoded-entry queue between fetch and
//            execute. Define CPU6_DEC_RV32M_EN to decode RV32M as legal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu6_decq
    import cpu6_decq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int QDEPTH  = 2,
    parameter int ALUOP_W = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                f_valid,
    output logic                                f_ready,
    input  logic [31:0]                         f_instr,
    input  logic [XLEN-1:0]                     f_pc,
    output logic                                d_valid,
    input  logic                                d_ready,
    output logic [XLEN-1:0]                     d_pc,
    output logic [31:0]                         d_instr,
    output logic [CPU6_DCTRL_FIX_W+ALUOP_W-1:0] d_ctrl,
    output logic                                d_illinstr,
    output logic [$clog2(QDEPTH):0]             d_count
);

    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int CTRL_W  = CPU6_DCTRL_FIX_W + ALUOP_W;
    localparam int ENTRY_W = 1 + 32 + XLEN + CTRL_W;

    logic [CTRL_W-1:0]  w_dec_ctrl;
    logic               w_dec_ill;
    logic               w_push, w_pop, w_full, w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] r_mem [QDEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [CNT_W-1:0]   r_count;

    cpu6_decq_dec #(.ALUOP_W(ALUOP_W)) u_dec (
        .instr    (f_instr),
        .ctrl     (w_dec_ctrl),
        .illinstr (w_dec_ill)
    );

    assign w_full  = (r_count == CNT_W'(QDEPTH));
    assign w_empty = (r_count == '0);
    assign d_valid = !w_empty;
    assign w_pop   = d_valid && d_ready;
    assign f_ready = !w_full || w_pop;
    assign w_push  = f_valid && f_ready && !flush;
    assign d_count = r_count;

    // Head is read straight from storage; an empty queue presents all zeros.
    assign w_head = w_empty ? '0 : r_mem[r_rptr];
    assign {d_illinstr, d_instr, d_pc, d_ctrl} = w_head;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {w_dec_ill, f_instr, f_pc, w_dec_ctrl};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

`default_nettype wire
